pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter STAGES, default 3, meaning the number of in-flight result stages after decode (index 0 = EX, 1 = MEM, 2 = WB); legal range 2..8.
REQ-002 Parameter REG_AW, default 5, meaning the register address width.
REQ-003 Parameter NUM_SRC, default 2, meaning the number of source operands checked per decoded instruction; legal range 1..4.
REQ-004 Derived widths: SELW = clog2(STAGES+1); RW = max(1, clog2(STAGES)).
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 issue_valid  in  1  the decode stage holds a valid instruction.
REQ-008 issue_wr  in  1  the decode instruction writes a register.
REQ-009 issue_rd  in  REG_AW  destination register of the decode instruction.
REQ-010 issue_ready_at  in  RW  first stage index whose output can forward the result (ALU = 0, load = 1).
REQ-011 src_addr  in  NUM_SRC*REG_AW  source register addresses, packed with source j at bits [j*REG_AW +: REG_AW].
REQ-012 src_used  in  NUM_SRC  per-source flag: the source is actually read.
REQ-013 flush_i  in  1  redirect; kills the decode instruction.
REQ-014 ext_stall  in  1  downstream freeze (for example, memory busy).
REQ-015 stall_o  out  1  hold PC and IF/ID this cycle.
REQ-016 issue_fire  out  1  the decode instruction enters EX at the next edge.
REQ-017 fwd_sel  out  NUM_SRC*SELW  per-source operand select: 0 = register file, k = output of stage index k-1.
REQ-018 stage_valid  out  STAGES  valid bit of each in-flight entry.
REQ-019 stage_rd  out  STAGES*REG_AW  destination register of each in-flight entry.

Function
REQ-020 The block SHALL hold a shift register of STAGES entries; each entry is {valid, wr, rd, ready_at}.
REQ-021 When ext_stall=0, at each edge:
- entry[0] SHALL load the decode instruction if issue_fire=1, otherwise a bubble (valid=0);
- entry[i] SHALL load entry[i-1] for i ≥ 1.
REQ-022 When ext_stall=1, all entries SHALL hold their values.
REQ-023 Source j SHALL match entry i when all of the following hold: src_used[j]=1, src_addr[j]≠0, entry[i].valid=1, entry[i].wr=1, and entry[i].rd=src_addr[j].
REQ-024 The youngest matching entry (lowest i) SHALL decide source j; older matches SHALL be ignored.
REQ-025 If the deciding entry has i < ready_at, source j SHALL raise a data hazard; otherwise fwd_sel[j] SHALL equal i+1.
REQ-026 With no match, fwd_sel[j] SHALL be 0; register 0 SHALL never match.
REQ-027 stall_o SHALL equal (any data hazard AND issue_valid) OR ext_stall; it SHALL be purely combinational from the current inputs and state.
REQ-028 issue_fire SHALL equal issue_valid AND NOT stall_o AND NOT flush_i.
REQ-029 A hazard SHALL insert exactly (ready_at - i) bubbles before the instruction issues, provided ext_stall stays 0.
REQ-030 When flush_i and a data hazard occur together, the instruction SHALL be dropped, a bubble SHALL enter EX, and in-flight entries SHALL be unaffected.
REQ-031 When ext_stall and flush_i occur together, there SHALL be no issue and all entries SHALL hold.
REQ-032 When issue_valid=0, stall_o SHALL equal ext_stall, and fwd_sel SHALL still be computed from src_addr.
REQ-033 Entries leaving entry[STAGES-1] SHALL be discarded; the register file write at that point is outside this block.

Reset
REQ-034 While rst=0: every entry.valid=0, wr=0, rd=0, ready_at=0.
REQ-035 Consequently, during reset stage_valid=0, stage_rd=0, and fwd_sel=0 for all sources; stall_o=ext_stall and issue_fire=0 are forced.
REQ-036 Reset asserted mid-stall SHALL clear all state immediately; the first edge after release SHALL see an empty pipe.

Configuration
REQ-037 When macro PIPE_HAZARD_STAT_EN is defined, the block SHALL add output hazard_cnt (out, 32 bits), which:
- increments on each edge where a data hazard caused stall_o=1 with ext_stall=0;
- saturates at 0xFFFFFFFF;
- resets to 0.
REQ-038 When PIPE_HAZARD_STAT_EN is undefined, the port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-039 ALU back-to-back: issue r3 (ready_at=0), then a reader of r3 → the next cycle shows fwd_sel[0]=1 and stall_o=0.
REQ-040 Load-use: issue r5 (ready_at=1), then a reader of r5 → stall_o=1 for one cycle, then fwd_sel=2, and issue_fire rises; hazard_cnt=1 if the macro is enabled.
REQ-041 Youngest wins: r7 written by the instructions in MEM and in EX (both ALU) → fwd_sel=1, not 2.
REQ-042 Register 0: in-flight write to r0 and a source reading r0 with src_used=1 → fwd_sel=0 and stall_o=0.
REQ-043 ext_stall held for 3 cycles with 2 valid entries → stage_valid unchanged for 3 cycles and issue_fire=0; release → shift resumes.
REQ-044 Reset during a load-use stall: rst=0 → stage_valid=0 and stall_o=0 immediately; after release, a reader of r5 issues with fwd_sel=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: in-order pipeline scoreboard. Tracks in-flight destination
// registers and produces operand forwarding selects and the decode stall.
// Optional feature: define PIPE_HAZARD_STAT_EN to add the 32-bit hazard_cnt
// output counting data-hazard stall cycles.
module pipe_hazard_ctrl #(
    parameter int STAGES  = 3,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    localparam int SELW   = $clog2(STAGES + 1),
    localparam int RW     = ($clog2(STAGES) > 1) ? $clog2(STAGES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [RW-1:0]             issue_ready_at,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic                      flush_i,
    input  logic                      ext_stall,
    output logic                      stall_o,
    output logic                      issue_fire,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*REG_AW-1:0]  stage_rd
`ifdef PIPE_HAZARD_STAT_EN
    ,
    output logic [31:0]               hazard_cnt
`endif
);

    logic              vld_q [STAGES];
    logic              wr_q  [STAGES];
    logic [REG_AW-1:0] rd_q  [STAGES];
    logic [RW-1:0]     rdy_q [STAGES];

    logic              vld_d [STAGES];
    logic              wr_d  [STAGES];
    logic [REG_AW-1:0] rd_d  [STAGES];
    logic [RW-1:0]     rdy_d [STAGES];

    logic              haz_any;
    logic              hit;
    logic [SELW-1:0]   hit_idx;
    logic [RW-1:0]     hit_rdy;
    logic [REG_AW-1:0] src;

    // Per-source match search: youngest matching entry decides forward vs. hazard
    always_comb begin
        haz_any = 1'b0;
        fwd_sel = '0;
        hit     = 1'b0;
        hit_idx = '0;
        hit_rdy = '0;
        src     = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            hit     = 1'b0;
            hit_idx = '0;
            hit_rdy = '0;
            src     = src_addr[j*REG_AW +: REG_AW];
            // Walk oldest to youngest so the youngest match overwrites older ones
            for (int i = STAGES - 1; i >= 0; i--) begin
                if (src_used[j] && (src != '0) && vld_q[i] && wr_q[i] && (rd_q[i] == src)) begin
                    hit     = 1'b1;
                    hit_idx = SELW'(i);
                    hit_rdy = rdy_q[i];
                end
            end
            if (hit) begin
                if (SELW'(hit_rdy) > hit_idx) begin
                    haz_any = 1'b1;
                end else begin
                    fwd_sel[j*SELW +: SELW] = hit_idx + SELW'(1);
                end
            end
        end
    end

    // Decode handshake; rst gating keeps issue off while reset is held
    always_comb begin
        stall_o    = (haz_any & issue_valid) | ext_stall;
        issue_fire = issue_valid & ~stall_o & ~flush_i & rst;
    end

    // Next-state of the in-flight shift register: advance unless frozen
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            vld_d[i] = vld_q[i];
            wr_d[i]  = wr_q[i];
            rd_d[i]  = rd_q[i];
            rdy_d[i] = rdy_q[i];
        end
        if (!ext_stall) begin
            vld_d[0] = issue_fire;
            wr_d[0]  = issue_fire & issue_wr;
            rd_d[0]  = issue_fire ? issue_rd : '0;
            rdy_d[0] = issue_fire ? issue_ready_at : '0;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                wr_d[i]  = wr_q[i-1];
                rd_d[i]  = rd_q[i-1];
                rdy_d[i] = rdy_q[i-1];
            end
        end
    end

    // In-flight entry registers, fully cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i] <= 1'b0;
                wr_q[i]  <= 1'b0;
                rd_q[i]  <= '0;
                rdy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i] <= vld_d[i];
                wr_q[i]  <= wr_d[i];
                rd_q[i]  <= rd_d[i];
                rdy_q[i] <= rdy_d[i];
            end
        end
    end

    // Flatten entry state onto the observation ports
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_valid[i]                = vld_q[i];
            stage_rd[i*REG_AW +: REG_AW]  = rd_q[i];
        end
    end

`ifdef PIPE_HAZARD_STAT_EN
    logic [31:0] hazard_cnt_q;
    logic [31:0] hazard_cnt_d;

    // Saturating count of cycles stalled by a data hazard alone
    always_comb begin
        hazard_cnt_d = hazard_cnt_q;
        if (haz_any && issue_valid && !ext_stall && (hazard_cnt_q != 32'hFFFF_FFFF)) begin
            hazard_cnt_d = hazard_cnt_q + 32'd1;
        end
    end

    // Hazard counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hazard_cnt_q <= '0;
        end else begin
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign hazard_cnt = hazard_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (default parameters: 3 stages,
// 5-bit register addresses, 2 sources). Honours PIPE_HAZARD_STAT_EN.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wr, flush_i, ext_stall;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_ready_at;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic        stall_o, issue_fire;
    logic [3:0]  fwd_sel;
    logic [2:0]  stage_valid;
    logic [14:0] stage_rd;
`ifdef PIPE_HAZARD_STAT_EN
    logic [31:0] hazard_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_wr       (issue_wr),
        .issue_rd       (issue_rd),
        .issue_ready_at (issue_ready_at),
        .src_addr       (src_addr),
        .src_used       (src_used),
        .flush_i        (flush_i),
        .ext_stall      (ext_stall),
        .stall_o        (stall_o),
        .issue_fire     (issue_fire),
        .fwd_sel        (fwd_sel),
        .stage_valid    (stage_valid),
        .stage_rd       (stage_rd)
`ifdef PIPE_HAZARD_STAT_EN
        ,
        .hazard_cnt     (hazard_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one decode-stage vector and let combinational outputs settle
    task automatic drive(input logic v, input logic wr, input logic [4:0] rd,
                         input logic [1:0] rdy, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic fl, input logic xs);
        issue_valid    = v;
        issue_wr       = wr;
        issue_rd       = rd;
        issue_ready_at = rdy;
        src_addr       = {s1, s0};
        src_used       = used;
        flush_i        = fl;
        ext_stall      = xs;
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        // Reset state with a would-be issue present
        drive(1, 1, 5'd3, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        chk("rst_valid", 32'(stage_valid), 32'h0);
        chk("rst_rd", 32'(stage_rd), 32'h0);
        chk("rst_fwd", 32'(fwd_sel), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_fire", 32'(issue_fire), 32'h0);
        tick();
        rst = 1'b1;

        // ALU back-to-back forwarding from EX
        drive(1, 1, 5'd3, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        chk("alu_issue_fire", 32'(issue_fire), 32'h1);
        tick();
        drive(1, 1, 5'd4, 0, 5'd3, 5'd0, 2'b01, 0, 0);
        chk("alu_fwd", 32'(fwd_sel), 32'h1);
        chk("alu_stall", 32'(stall_o), 32'h0);
        chk("alu_valid", 32'(stage_valid), 32'h1);
        chk("alu_rd0", 32'(stage_rd[4:0]), 32'd3);
        tick();

        // Youngest wins: r7 in EX and MEM, r4 in WB
        drive(1, 1, 5'd7, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 5'd7, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 0, 5'd0, 0, 5'd4, 5'd7, 2'b11, 0, 0);
        chk("young_fwd", 32'(fwd_sel), 32'h7);
        chk("young_stall", 32'(stall_o), 32'h0);
        tick();

        // Register 0 never matches, even for a load in EX
        drive(1, 1, 5'd0, 1, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 0, 5'd0, 0, 5'd0, 5'd0, 2'b01, 0, 0);
        chk("r0_fwd", 32'(fwd_sel), 32'h0);
        chk("r0_stall", 32'(stall_o), 32'h0);
        tick();

        // Load-use: one bubble then forward from MEM
        drive(1, 1, 5'd5, 1, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 5'd6, 0, 5'd5, 5'd0, 2'b01, 0, 0);
        chk("lu_stall", 32'(stall_o), 32'h1);
        chk("lu_fire0", 32'(issue_fire), 32'h0);
        tick();
        drive(1, 1, 5'd6, 0, 5'd5, 5'd0, 2'b01, 0, 0);
        chk("lu_stall_done", 32'(stall_o), 32'h0);
        chk("lu_fwd", 32'(fwd_sel), 32'h2);
        chk("lu_fire1", 32'(issue_fire), 32'h1);
        chk("lu_bubble", 32'(stage_valid), 32'h6);
`ifdef PIPE_HAZARD_STAT_EN
        chk("lu_hazard_cnt", hazard_cnt, 32'd1);
`endif
        tick();

        // ext_stall freeze with two valid entries (r6 in EX, r5 in WB)
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'd8, 0, 5'd0, 5'd0, 2'b00, (k == 1), 1);
            chk("xs_stall", 32'(stall_o), 32'h1);
            chk("xs_fire", 32'(issue_fire), 32'h0);
            chk("xs_valid", 32'(stage_valid), 32'h5);
            chk("xs_rd0", 32'(stage_rd[4:0]), 32'd6);
            tick();
        end
        drive(1, 1, 5'd8, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        chk("xs_release_fire", 32'(issue_fire), 32'h1);
        tick();
        drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        chk("xs_shift_valid", 32'(stage_valid), 32'h3);
        chk("xs_shift_rd", 32'(stage_rd[9:0]), 32'({5'd6, 5'd8}));

        // Flush during a load-use hazard: drop, bubble, entries untouched
        drive(1, 1, 5'd9, 1, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 5'd10, 0, 5'd9, 5'd0, 2'b01, 1, 0);
        chk("fl_stall", 32'(stall_o), 32'h1);
        chk("fl_fire", 32'(issue_fire), 32'h0);
        tick();
        // No valid decode: forwarding still computed, stall follows ext_stall
        drive(0, 0, 5'd0, 0, 5'd9, 5'd0, 2'b01, 0, 0);
        chk("fl_valid", 32'(stage_valid), 32'h6);
        chk("fl_rd", 32'(stage_rd[14:5]), 32'({5'd8, 5'd9}));
        chk("nv_fwd", 32'(fwd_sel), 32'h2);
        chk("nv_stall", 32'(stall_o), 32'h0);
        tick();

        // Reset asserted during a load-use stall
        drive(1, 1, 5'd5, 1, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 5'd6, 0, 5'd5, 5'd0, 2'b01, 0, 0);
        chk("rs_pre_stall", 32'(stall_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("rs_valid", 32'(stage_valid), 32'h0);
        chk("rs_stall", 32'(stall_o), 32'h0);
        chk("rs_fire", 32'(issue_fire), 32'h0);
        chk("rs_fwd", 32'(fwd_sel), 32'h0);
`ifdef PIPE_HAZARD_STAT_EN
        chk("rs_hazard_cnt", hazard_cnt, 32'd0);
`endif
        tick();
        rst = 1'b1;
        drive(1, 1, 5'd6, 0, 5'd5, 5'd0, 2'b01, 0, 0);
        chk("rs_after_fwd", 32'(fwd_sel), 32'h0);
        chk("rs_after_fire", 32'(issue_fire), 32'h1);
        tick();
        drive(0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        chk("rs_after_valid", 32'(stage_valid), 32'h1);
        chk("rs_after_rd", 32'(stage_rd[4:0]), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
